// File: rtl/mult_div_unit_pkg.sv
// Shared encodings for the multiply/divide unit.
// Decoder and hazard logic reference these names too.
package mult_div_unit_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } md_state_e;

endpackage

// File: rtl/mult_div_unit_iter.sv
// One radix-2 step: shift-add multiply or
// restoring shift-subtract divide.
module mult_div_iter #(
  parameter int W = 32
) (
  input  logic [2*W-1:0] acc,
  input  logic [W-1:0]   opnd,
  input  logic           is_div,
  output logic [2*W-1:0] acc_nxt,
  output logic           qbit
);

  logic [W:0] sum;
  logic [W:0] rsh;
  logic [W:0] diff;

  always_comb begin
    acc_nxt = '0;
    qbit    = 1'b0;
    sum  = {1'b0, acc[2*W-1:W]}
         + (acc[0] ? {1'b0, opnd} : '0);
    // partial remainder shifted left with the next dividend bit
    rsh  = acc[2*W-1:W-1];
    diff = rsh - {1'b0, opnd};
    if (is_div) begin
      qbit    = ~diff[W];
      acc_nxt = {qbit ? diff[W-1:0] : rsh[W-1:0],
                 acc[W-2:0], 1'b0};
    end else begin
      acc_nxt = {sum, acc[W-1:1]};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide engine feeding
// the HI/LO register pair.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Clr,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic             HiLd,
  output logic             LoLd,
  output logic [WIDTH-1:0] HiOut,
  output logic [WIDTH-1:0] LoOut
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  md_state_e state, state_nxt;

  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc, acc_nxt;
  logic [WIDTH-1:0]   opnd, a_raw;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               is_div, neg_q, neg_r;
  logic               dz, qbit, done_q;
  logic               sgn, opdiv;
  logic [WIDTH-1:0]   a_abs, b_abs;

  assign sgn   = (Op == OP_MULT) || (Op == OP_DIV);
  assign opdiv = (Op == OP_DIV) || (Op == OP_DIVU);
  assign a_abs = (sgn && A[WIDTH-1]) ? -A : A;
  assign b_abs = (sgn && B[WIDTH-1]) ? -B : B;

  mult_div_iter #(.W(WIDTH)) u_iter (
    .acc    (acc),
    .opnd   (opnd),
    .is_div (is_div),
    .acc_nxt(acc_nxt),
    .qbit   (qbit)
  );

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (Start) state_nxt = S_CALC;
      S_CALC: if (cnt == LAST) state_nxt = S_FIX;
      S_FIX:  state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      a_raw  <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      // strobes come straight from a flop, one cycle after DONE
      done_q <= (state == S_DONE);
      case (state)
        S_IDLE: if (Start) begin
          cnt    <= '0;
          is_div <= opdiv;
          a_raw  <= A;
          neg_q  <= sgn && (A[WIDTH-1] ^ B[WIDTH-1]);
          neg_r  <= sgn && A[WIDTH-1];
          dz     <= opdiv && (B == '0);
          opnd   <= opdiv ? b_abs : a_abs;
          acc    <= opdiv ? {{WIDTH{1'b0}}, a_abs}
                          : {{WIDTH{1'b0}}, b_abs};
        end
        S_CALC: begin
          acc <= acc_nxt | {{(2*WIDTH-1){1'b0}}, qbit};
          cnt <= cnt + 1'b1;
        end
        S_FIX: begin
          unique case (1'b1)
            !is_div: {hi_q, lo_q} <= neg_q ? -acc : acc;
            dz: begin
              hi_q <= a_raw;
              lo_q <= '1;
            end
            default: begin
              lo_q <= neg_q ? -acc[WIDTH-1:0]
                            : acc[WIDTH-1:0];
              hi_q <= neg_r ? -acc[2*WIDTH-1:WIDTH]
                            : acc[2*WIDTH-1:WIDTH];
            end
          endcase
        end
        default: ;
      endcase
    end
  end

  assign Busy  = (state != S_IDLE) || done_q;
  assign Done  = done_q;
  assign HiLd  = done_q;
  assign LoLd  = done_q;
  assign HiOut = hi_q;
  assign LoOut = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: arithmetic reference model
// checked every cycle plus literal directed results.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  logic        Clk = 1'b0;
  logic        Clr = 1'b0;
  logic        Start = 1'b0;
  logic [1:0]  Op = 2'b00;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        Busy, Done, HiLd, LoLd;
  logic [31:0] HiOut, LoOut;

  mult_div_unit #(.WIDTH(32)) dut (
    .Clk  (Clk),
    .Clr  (Clr),
    .Start(Start),
    .Op   (Op),
    .A    (A),
    .B    (B),
    .Busy (Busy),
    .Done (Done),
    .HiLd (HiLd),
    .LoLd (LoLd),
    .HiOut(HiOut),
    .LoOut(LoOut)
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit run = 1'b0;

  // mk: edges since the accepting edge, -1 when idle
  int          mk = -1;
  logic [31:0] mhi = '0;
  logic [31:0] mlo = '0;
  logic [31:0] phi = '0;
  logic [31:0] plo = '0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] model_res(
    input logic [1:0] op,
    input logic [31:0] a,
    input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p = '0;
    case (op)
      OP_MULT:  p = sa * sb;
      OP_MULTU: p = {32'h0, a} * {32'h0, b};
      default: begin
        if (b == 32'h0) p = {a, 32'hFFFF_FFFF};
        else if (op == OP_DIVU) p = {a % b, a / b};
        else begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end
      end
    endcase
    return p;
  endfunction

  always @(posedge Clk or posedge Clr) begin
    int prek;
    logic [63:0] r;
    if (Clr) begin
      mk = -1;
      mhi = '0;
      mlo = '0;
    end else begin
      prek = mk;
      if ((prek == -1 || prek == 34) && Start) begin
        mk = 0;
        r = model_res(Op, A, B);
        phi = r[63:32];
        plo = r[31:0];
      end else if (prek == 34) mk = -1;
      else if (prek >= 0) mk = prek + 1;
      if (mk == 33) begin
        mhi = phi;
        mlo = plo;
      end
    end
  end

  always @(negedge Clk) begin
    logic eb, ed;
    if (run) begin
      eb = (mk >= 0) && (mk <= 34);
      ed = (mk == 34);
      chk("busy", Busy, eb);
      chk("done", Done, ed);
      chk("hild", HiLd, ed);
      chk("lold", LoLd, ed);
      chk("hiout", HiOut, mhi);
      chk("loout", LoOut, mlo);
    end
  end

  task automatic run_op(input string nm,
                        input logic [1:0] op,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [31:0] ehi,
                        input logic [31:0] elo,
                        input bit lit,
                        input int glitch_at,
                        input int clr_at);
    bit got = 0;
    bit abt = 0;
    Op = op;
    A = a;
    B = b;
    Start = 1'b1;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    A = ~a;
    B = ~b;
    for (int i = 1; i <= 40; i++) begin
      @(posedge Clk);
      #1;
      Start = 1'b0;
      if (i == glitch_at) begin
        Start = 1'b1;
        Op = OP_DIVU;
        A = 32'd1;
        B = 32'd1;
      end
      if (i == clr_at) begin
        Clr = 1'b1;
        #1;
        chk({nm, "_clr_busy"}, Busy, 1'b0);
        chk({nm, "_clr_done"}, Done, 1'b0);
        chk({nm, "_clr_hi"}, HiOut, 32'h0);
        chk({nm, "_clr_lo"}, LoOut, 32'h0);
        @(posedge Clk);
        #1;
        Clr = 1'b0;
        abt = 1;
        break;
      end
      if (Done) begin
        got = 1;
        if (lit) begin
          chk({nm, "_latency"}, i, 34);
          chk({nm, "_hi"}, HiOut, ehi);
          chk({nm, "_lo"}, LoOut, elo);
          chk({nm, "_hild"}, HiLd, 1'b1);
          chk({nm, "_lold"}, LoLd, 1'b1);
        end
        break;
      end
    end
    if (!got && !abt) chk({nm, "_timeout"}, got, 1'b1);
  endtask

  initial begin
    int nd;
    logic [1:0] rop;
    #3 Clr = 1'b1;
    #1 run = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_busy", Busy, 1'b0);
    chk("rst_done", Done, 1'b0);
    chk("rst_hi", HiOut, 32'h0);
    chk("rst_lo", LoOut, 32'h0);
    Clr = 1'b0;

    run_op("multu_ff", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           32'hFFFF_FFFE, 32'h0000_0001, 1, 0, 0);
    run_op("mult_m3x7", OP_MULT, 32'hFFFF_FFFD, 32'd7,
           32'hFFFF_FFFF, 32'hFFFF_FFEB, 1, 0, 0);
    run_op("div_m7d2", OP_DIV, 32'hFFFF_FFF9, 32'd2,
           32'hFFFF_FFFF, 32'hFFFF_FFFD, 1, 0, 0);
    run_op("divu_100d7", OP_DIVU, 32'd100, 32'd7,
           32'd2, 32'd14, 1, 0, 0);
    run_op("divu_dz", OP_DIVU, 32'd5, 32'd0,
           32'd5, 32'hFFFF_FFFF, 1, 0, 0);
    run_op("div_dz", OP_DIV, 32'hFFFF_FFF9, 32'd0,
           32'hFFFF_FFF9, 32'hFFFF_FFFF, 1, 0, 0);
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
           32'h0, 32'h8000_0000, 1, 0, 0);
    run_op("mult_minmin", OP_MULT, 32'h8000_0000, 32'h8000_0000,
           32'h4000_0000, 32'h0, 1, 0, 0);
    run_op("mult_glitch", OP_MULT, 32'd1000, 32'hFFFF_FFFE,
           32'hFFFF_FFFF, 32'hFFFF_F830, 1, 10, 0);

    run_op("multu_clr", OP_MULTU, 32'h0000_FFFF, 32'h0000_FFFF,
           32'h0, 32'h0, 0, 0, 15);
    nd = 0;
    repeat (40) begin
      @(posedge Clk);
      #1;
      if (Done) nd++;
    end
    chk("no_done_after_clr", nd, 0);
    run_op("divu_after_clr", OP_DIVU, 32'd1000, 32'd10,
           32'd0, 32'd100, 1, 0, 0);

    for (int t = 0; t < 6; t++) begin
      rop = 2'($urandom_range(0, 3));
      run_op("rnd", rop, $urandom,
             (t % 2 == 1) ? 32'($urandom_range(1, 20)) : $urandom,
             32'h0, 32'h0, 0, 0, 0);
    end

    repeat (3) @(posedge Clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multi-cycle multiply/divide engine for the MIPS datapath; the producer side of the HI/LO register pair.
- Accepts an operation from the ID/EX stage and computes the 64-bit product or the quotient/remainder over several cycles.
- Drives result data plus one-cycle load strobes into the HI and LO registers; raises Busy so the hazard unit stalls mfhi/mflo.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.

Ports:
- Clk  input  1  system clock, rising-edge
- Clr  input  1  asynchronous, active-high reset
- Start  input  1  launch operation; sampled only in IDLE
- Op  input  2  00=mult, 01=multu, 10=div, 11=divu
- A  input  WIDTH  multiplicand / dividend
- B  input  WIDTH  multiplier / divisor
- Busy  output  1  high from the cycle after accepted Start through the DONE cycle
- Done  output  1  one-cycle pulse; results valid
- HiLd  output  1  HI register load strobe; equals Done
- LoLd  output  1  LO register load strobe; equals Done
- HiOut  output  WIDTH  mult: product[63:32]; div: remainder
- LoOut  output  WIDTH  mult: product[31:0]; div: quotient

Behaviour:
- Reset (Clr=1, asynchronous): state=IDLE; Busy, Done, HiLd, LoLd = 0; HiOut, LoOut = 0; internal accumulators and counter = 0.
- The FSM has four states: IDLE, CALC, FIX, DONE.
- IDLE: on an edge with Start=1, latch Op, A, B and go to CALC with count=0.
  - For signed ops, latch |A| and |B|; record product/quotient sign = A[31]^B[31] and remainder sign = A[31].
- CALC: one radix-2 iteration per cycle.
  - Multiply: shift-add on a 64-bit accumulator.
  - Divide: restoring shift-subtract.
  - After the iteration with count==WIDTH-1, go to FIX.
- FIX: apply sign correction (two's complement negation of the product, or of the quotient/remainder per the recorded signs). Register the results into HiOut/LoOut. Go to DONE.
- DONE: Done=HiLd=LoLd=1 for exactly one cycle, then go to IDLE.
- Latency: with Start sampled at edge 0, Done is high during the cycle after edge WIDTH+2, i.e. 34 cycles for WIDTH=32.
- Busy is high in CALC, FIX and DONE.
- Start while not IDLE is ignored; it is neither queued nor allowed to corrupt the latched operands.
- HiOut/LoOut hold the last result until the next FIX. They are not cleared when Done falls.
- Divide by zero (B==0, div or divu): no trap; HiOut=A (original, unsigned view), LoOut=all ones. Latency is unchanged.
- Signed overflow (div, A=0x80000000, B=0xFFFFFFFF): LoOut=0x80000000, HiOut=0.
- mult with the most-negative operands: the full 64-bit result is exact (0x80000000*0x80000000 = 0x4000000000000000).
- Clr asserted mid-operation: immediate return to IDLE with all outputs zero. No HiLd/LoLd pulse for the aborted op.
- Start in the cycle right after DONE (back-to-back) is accepted normally.

Decomposition:
- Shared package / header: Op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU) and FSM state encodings, so the decoder and hazard unit can reference them.
- One sub-module, mult_div_iter: a combinational single-iteration datapath.
  - Inputs: accumulator, operand, op class.
  - Outputs: next accumulator and quotient bit.
- The top holds the FSM, counter, sign bookkeeping and output registers.

Test Plan:
- multu A=0xFFFFFFFF, B=0xFFFFFFFF -> Done at cycle 34; HiOut=0xFFFFFFFE, LoOut=0x00000001; HiLd=LoLd=1 for one cycle.
- mult A=0xFFFFFFFD (-3), B=7 -> HiOut=0xFFFFFFFF, LoOut=0xFFFFFFEB (-21).
- div A=0xFFFFFFF9 (-7), B=2 -> LoOut=0xFFFFFFFD (-3), HiOut=0xFFFFFFFF (-1).
- divu A=100, B=7 -> LoOut=14, HiOut=2.
- divu A=5, B=0 -> LoOut=0xFFFFFFFF, HiOut=5.
- div A=0x80000000, B=0xFFFFFFFF -> LoOut=0x80000000, HiOut=0.
- Start pulsed again at cycle 10 of a mult -> ignored; the original result is unchanged.
- Clr at cycle 15 -> Busy=0, HiOut=LoOut=0 and no Done; a new Start afterwards completes normally.
